// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: runs WIDTH-bit AND/OR/XOR/ADD through a 1-bit ALU slice, LSB first; optional macro SERIAL_ALU_ZERO_FLAG_EN adds a zero flag
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    , output logic           zero
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nx;
    logic [1:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             carry, carry_nx, bit_v, last;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             zacc;
`endif
    // 1-bit ALU slice: op[0] selects whether the carry joins the XOR (ADD vs XOR)
    always_comb begin
        bit_v    = (op_r == 2'b00) ? (a_sr[0] & b_sr[0]) :
                   (op_r == 2'b01) ? (a_sr[0] | b_sr[0]) :
                   (a_sr[0] ^ b_sr[0] ^ (op_r[0] & carry));
        carry_nx = (op_r == 2'b11) ? ((a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]))) : 1'b0;
        r_nx     = {bit_v, r_sr[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Next state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN: begin
                busy     = 1'b1;
                state_nx = last ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Operand latch, bit-serial shifting and result capture on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            op_r      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zacc      <= 1'b0;
            zero      <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_sr  <= A;
            b_sr  <= B;
            op_r  <= op;
            cnt   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zacc  <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_nx;
            carry <= carry_nx;
            cnt   <= cnt + 1'b1;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zacc  <= zacc | bit_v;
`endif
            if (last) begin
                result    <= r_nx;
                carry_out <= carry_nx;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                zero      <= ~(zacc | bit_v);
`endif
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb_bit_serial_alu_ctrl: randomized self-checking bench for bit_serial_alu_ctrl against an arithmetic reference model
module tb_bit_serial_alu_ctrl;
    localparam int W = 8;
    logic         clk = 0, rst = 1, start = 0;
    logic [1:0]   op = 0;
    logic [W-1:0] A = 0, B = 0;
    logic         busy, done, carry_out;
    logic [W-1:0] result;
    int checks = 0, failures = 0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic zero;
`endif

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'd0:    return {1'b0, a & b};
            2'd1:    return {1'b0, a | b};
            2'd2:    return {1'b0, a ^ b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    // Issues one start pulse, scrambles inputs afterwards, and observes a fixed window
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_n, output int dones, output bit moved, output bit both);
        logic [W-1:0] r0;
        r0 = result; lat = 0; busy_n = 0; dones = 0; moved = 0; both = 0;
        @(negedge clk); op = o; A = a; B = b; start = 1;
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            start = 0; A = W'($urandom); B = W'($urandom); op = 2'($urandom);
            if (dones == 0 && !done && result !== r0) moved = 1;
            if (busy) busy_n++;
            if (busy && done) both = 1;
            if (done) begin
                dones++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, result, carry_out} !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%h carry=%b, required all 0", busy, done, result, carry_out);
        end
        rst = 0;
    endtask

    task automatic test_xor;
        int lat, bn, dn; bit mv, bo;
        do_op(2'b10, 8'hA5, 8'h3C, lat, bn, dn, mv, bo);
        checks++;
        if (bn !== W || lat !== W + 1 || dn !== 1) begin
            failures++;
            $display("FAIL xor_timing: busy_cycles=%0d done_at=%0d dones=%0d, required %0d %0d 1", bn, lat, dn, W, W + 1);
        end
        checks++;
        if (result !== 8'h99 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL xor_result: result=%h carry=%b, required 99 0", result, carry_out);
        end
    endtask

    task automatic test_add_overflow;
        int lat, bn, dn; bit mv, bo;
        do_op(2'b11, 8'hFF, 8'h01, lat, bn, dn, mv, bo);
        checks++;
        if (result !== 8'h00 || carry_out !== 1'b1 || dn !== 1) begin
            failures++;
            $display("FAIL add_overflow: result=%h carry=%b dones=%0d, required 00 1 1", result, carry_out, dn);
        end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b1) begin
            failures++;
            $display("FAIL zero_set: zero=%b, required 1", zero);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int t1, t2, n;
        logic [W-1:0] r1;
        t1 = 0; t2 = 0; n = 0; r1 = 0;
        @(negedge clk); op = 2'b00; A = 8'hF0; B = 8'h3C; start = 1;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (done && t1 == 0) begin
                t1 = i; r1 = result; op = 2'b01;
            end else if (done && t2 == 0) begin
                t2 = i; start = 0;
            end
            if (t2 != 0) break;
        end
        start = 0;
        checks++;
        if (r1 !== 8'h30) begin
            failures++;
            $display("FAIL b2b_and: result=%h, required 30", r1);
        end
        checks++;
        if (result !== 8'hFC) begin
            failures++;
            $display("FAIL b2b_or: result=%h, required fc", result);
        end
        checks++;
        if (t1 == 0 || t2 == 0 || t2 - t1 !== W + 2) begin
            failures++;
            $display("FAIL b2b_spacing: first=%0d second=%0d, required spacing %0d", t1, t2, W + 2);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int dn;
        dn = 0;
        @(negedge clk); op = 2'b11; A = 8'h12; B = 8'h34; start = 1;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            start = 0;
            if (i == 3) begin
                start = 1; op = 2'b10; A = 8'hFF; B = 8'hFF;
            end
            if (done) dn++;
        end
        checks++;
        if (result !== 8'h46 || carry_out !== 1'b0 || dn !== 1) begin
            failures++;
            $display("FAIL ignore_start: result=%h carry=%b dones=%0d, required 46 0 1", result, carry_out, dn);
        end
    endtask

    task automatic test_reset_midop;
        int lat, bn, dn; bit mv, bo; int bad_done;
        bad_done = 0;
        do_op(2'b11, 8'h80, 8'h80, lat, bn, dn, mv, bo);
        checks++;
        if (result !== 8'h00 || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL add_80_80: result=%h carry=%b, required 00 1", result, carry_out);
        end
        @(negedge clk); op = 2'b11; A = 8'h55; B = 8'h55; start = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 0;
        end
        rst = 1;
        #1;
        checks++;
        if ({busy, done, result, carry_out} !== '0) begin
            failures++;
            $display("FAIL midop_reset: busy=%b done=%b result=%h carry=%b, required all 0", busy, done, result, carry_out);
        end
        @(negedge clk); @(negedge clk);
        rst = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (done) bad_done++;
        end
        checks++;
        if (bad_done !== 0) begin
            failures++;
            $display("FAIL midop_no_done: dones=%0d, required 0", bad_done);
        end
        do_op(2'b10, 8'h0F, 8'h01, lat, bn, dn, mv, bo);
        checks++;
        if (result !== 8'h0E || lat !== W + 1) begin
            failures++;
            $display("FAIL after_reset: result=%h done_at=%0d, required 0e %0d", result, lat, W + 1);
        end
    endtask

    task automatic test_random;
        int lat, bn, dn; bit mv, bo;
        logic [1:0] o; logic [W-1:0] a, b; logic [W:0] exp;
        for (int n = 0; n < 200; n++) begin
            o = 2'($urandom); a = W'($urandom); b = W'($urandom);
            if (n % 16 == 0) b = (o == 2'b11) ? W'(-a) : '0;
            exp = model(o, a, b);
            do_op(o, a, b, lat, bn, dn, mv, bo);
            checks++;
            if (result !== exp[W-1:0] || carry_out !== exp[W]) begin
                failures++;
                $display("FAIL rand_result #%0d op=%0d a=%h b=%h: result=%h carry=%b, required %h %b", n, o, a, b, result, carry_out, exp[W-1:0], exp[W]);
            end
            checks++;
            if (dn !== 1 || lat !== W + 1 || bn !== W || bo || mv) begin
                failures++;
                $display("FAIL rand_protocol #%0d: dones=%0d done_at=%0d busy_cycles=%0d overlap=%b early_change=%b, required 1 %0d %0d 0 0", n, dn, lat, bn, bo, mv, W + 1, W);
            end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            checks++;
            if (zero !== (exp[W-1:0] == '0)) begin
                failures++;
                $display("FAIL rand_zero #%0d: zero=%b, required %b", n, zero, exp[W-1:0] == '0);
            end
`endif
        end
    endtask

    initial begin
        test_reset;
        test_xor;
        test_add_overflow;
        test_back_to_back;
        test_ignore_start;
        test_reset_midop;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
